// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX sides.
// Defining UART_TX_PARITY_EN adds the PARITY transmit state.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    ,
    PARITY
`endif
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: tick_o marks the last clock of each bit.
// A synchronous clear restarts the period so bit timing aligns to a frame start.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: pops one byte per frame from the TX FIFO and sends it LSB first.
// Build option UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_tx,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_q, bit_d;
  logic                 baud_clr;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (baud_clr),
    .tick_o(baud_tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    fifo_rd    = 1'b0;
    tx         = IDLE_LEVEL;
    busy       = 1'b1;
    frame_done = 1'b0;
    baud_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        baud_clr = 1'b1;
        // Gated by rst so a pop is never issued in a cycle whose state change is discarded.
        if (enable_tx && !fifo_empty && !rst) begin
          fifo_rd = 1'b1;
          busy    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shreg_d  = fifo_data;
        bit_d    = '0;
        baud_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d    = ^fifo_data;
`endif
        state_d  = START;
      end
      START: begin
        tx = START_LEVEL;
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        tx = shreg_q[0];
        if (baud_tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par_q;
        if (baud_tick) state_d = STOP;
      end
`endif
      STOP: begin
        tx = IDLE_LEVEL;
        if (baud_tick) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  // Payload registers carry no reset: they are always loaded in LOAD before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame at CLKS_PER_BIT=4, DATA_BITS=8.
// Expected line patterns are queued as bytes enter the FIFO model; a monitor decodes tx and compares.
module tb_uart_tx_frame;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif
  localparam int FL = NB * CPB;

  typedef struct packed {
    logic [7:0]  data;
    logic [10:0] line;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          enable_tx;
  logic          fifo_empty;
  logic [DB-1:0] fifo_data;
  logic          fifo_rd;
  logic          tx;
  logic          busy;
  logic          frame_done;

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable_tx (enable_tx),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         compared    = 0;
  int         errors      = 0;
  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];

  int cyc         = 0;
  int last_rd     = -100;
  int rd_count    = 0;
  int frames_done = 0;
  int aborted     = 0;
  int last_end    = -100;
  int last_gap    = -1;
  int k           = 0;
  bit in_frame    = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock of stimulus time; also plays the FIFO (data valid the cycle after fifo_rd).
  task automatic tick();
    bit pend;
    @(negedge clk);
    pend = fifo_rd;
    @(posedge clk);
    #1;
    if (pend && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // line10 is the hand-written 8N1 line in send order: bit0=start, bits8:1=data, bit9=stop.
  task automatic push_frame(input logic [7:0] data, input logic [9:0] line10, input logic par);
    exp_t e;
    e.data = data;
`ifdef UART_TX_PARITY_EN
    e.line = {1'b1, par, line10[8:0]};
`else
    e.line = {1'b0, line10};
`endif
    exp_q.push_back(e);
    fifo_q.push_back(data);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (frames_done < n && i < budget) begin
      tick();
      i++;
    end
    check($sformatf("frames_reach_%0d", n), frames_done, n);
  endtask

  task automatic wait_k(input int kk, input int budget);
    int i;
    i = 0;
    while (!(in_frame && k == kk) && i < budget) begin
      tick();
      i++;
    end
    check($sformatf("reach_frame_cycle_%0d", kk), (in_frame && k == kk), 1);
  endtask

  initial begin : monitor
    exp_t cur;
    int   bad;
    int   first_bad;
    cur       = '0;
    bad       = 0;
    first_bad = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (in_frame) aborted++;
        in_frame = 1'b0;
      end else begin
        if (fifo_rd) begin
          rd_count++;
          last_rd = cyc;
          check("fifo_rd_while_empty", fifo_empty, 0);
        end
        if (!in_frame && tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            compared++;
            errors++;
            $display("FAIL unexpected_frame: start bit at cycle %0d with no queued byte", cyc);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          check("start_latency", cyc - last_rd, 2);
          last_gap  = cyc - last_end - 1;
          in_frame  = 1'b1;
          k         = 0;
          bad       = 0;
          first_bad = -1;
        end
        if (in_frame) begin
          if (tx !== cur.line[k / CPB] || busy !== 1'b1 || frame_done !== (k == FL - 1)) begin
            bad++;
            if (first_bad < 0) first_bad = k;
          end
          k++;
          if (k == FL) begin
            check($sformatf("frame_%02h_bad_cycles_first_at_%0d", cur.data, first_bad), bad, 0);
            in_frame = 1'b0;
            frames_done++;
            last_end = cyc;
          end
        end else if (frame_done) begin
          compared++;
          errors++;
          $display("FAIL spurious_frame_done: got 1 expected 0 (cycle %0d)", cyc);
        end
      end
    end
  end

  initial begin : stim
    int bad;
    rst        = 1'b1;
    enable_tx  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    tick();
    tick();
    check("rst_tx", tx, 1);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst       = 1'b0;
    enable_tx = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_empty_bad_cycles", bad, 0);

    // Single frame 0xA5
    push_frame(8'hA5, 10'b1_10100101_0, 1'b0);
    wait_frames(1, 100);
    check("rd_count_a5", rd_count, 1);

    // Back-to-back 0x00 then 0xFF
    push_frame(8'h00, 10'b1_00000000_0, 1'b0);
    push_frame(8'hFF, 10'b1_11111111_0, 1'b0);
    wait_frames(3, 200);
    check("rd_count_b2b", rd_count, 3);
    check("b2b_idle_gap", last_gap, 2);

    // enable_tx dropped during DATA of 0x3C
    push_frame(8'h3C, 10'b1_00111100_0, 1'b0);
    wait_k(12, 60);
    enable_tx = 1'b0;
    push_frame(8'h5A, 10'b1_01011010_0, 1'b0);
    wait_frames(4, 100);
    repeat (30) tick();
    check("rd_count_disabled", rd_count, 4);
    check("frames_disabled", frames_done, 4);
    enable_tx = 1'b1;
    wait_frames(5, 100);
    check("rd_count_reenabled", rd_count, 5);

    // Reset during data bit 3 of 0xC3
    push_frame(8'hC3, 10'b1_11000011_0, 1'b0);
    wait_k(17, 60);
    rst = 1'b1;
    tick();
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    rst = 1'b0;
    check("aborted_frames", aborted, 1);
    push_frame(8'h97, 10'b1_10010111_0, 1'b1);
    wait_frames(6, 100);
    check("rd_count_after_rst", rd_count, 7);

`ifdef UART_TX_PARITY_EN
    push_frame(8'h07, 10'b1_00000111_0, 1'b1);
    push_frame(8'h03, 10'b1_00000011_0, 1'b0);
    wait_frames(8, 200);
    check("rd_count_parity", rd_count, 9);
`endif

    repeat (5) tick();
    check("leftover_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
